// File: rtl/warp_pc_scheduler.sv
// Per-warp PC holder and round-robin fetch arbiter with one instruction
// in flight per warp.
module warp_pc_scheduler #(
  parameter int unsigned     NUM_WARPS = 8,
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] START_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WARPS-1:0]         warp_start,
  input  logic                         start_pc_valid,
  input  logic [PC_W-1:0]              start_pc,
  input  logic [NUM_WARPS-1:0]         ib_full,
  input  logic [NUM_WARPS-1:0]         simt_full,
  input  logic                         if_ready,
  output logic                         if_valid,
  output logic [$clog2(NUM_WARPS)-1:0] if_warp_id,
  output logic [PC_W-1:0]              if_pc,
  input  logic                         id0_upd,
  input  logic [NUM_WARPS-1:0]         id0_warp,
  input  logic                         id0_branch,
  input  logic                         id0_exit,
  input  logic [PC_W-1:0]              id0_next_pc,
  input  logic                         id1_upd,
  input  logic [NUM_WARPS-1:0]         id1_warp,
  input  logic                         id1_branch,
  input  logic                         id1_exit,
  input  logic [PC_W-1:0]              id1_next_pc,
  input  logic                         alu_redirect,
  input  logic [$clog2(NUM_WARPS)-1:0] alu_warp_id,
  input  logic [PC_W-1:0]              alu_target,
  output logic [NUM_WARPS-1:0]         warp_busy,
  output logic                         all_done
);

  localparam int unsigned WID_W = $clog2(NUM_WARPS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_WAIT_BR = 3'd3,
    S_DONE    = 3'd4
  } wstate_e;

  wstate_e              state_q [NUM_WARPS];
  wstate_e              state_d [NUM_WARPS];
  logic [PC_W-1:0]      pc_q    [NUM_WARPS];
  logic [PC_W-1:0]      pc_d    [NUM_WARPS];
  logic [WID_W-1:0]     rr_ptr_q;
  logic [WID_W-1:0]     rr_ptr_d;
  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] started;
  logic [NUM_WARPS-1:0] finished;
  logic [WID_W-1:0]     cand;
  logic                 handshake;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        state_q[w] <= S_IDLE;
        pc_q[w]    <= '0;
      end
      rr_ptr_q <= WID_W'(NUM_WARPS - 1);
    end else begin
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        state_q[w] <= state_d[w];
        pc_q[w]    <= pc_d[w];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign handshake = if_valid && if_ready;

  // Next-state: per-warp transitions and round-robin pointer update
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (handshake) rr_ptr_d = if_warp_id;
    for (int w = 0; w < int'(NUM_WARPS); w++) begin
      state_d[w] = state_q[w];
      pc_d[w]    = pc_q[w];
      case (state_q[w])
        S_IDLE: begin
          if (warp_start[w]) begin
            state_d[w] = S_READY;
            pc_d[w]    = start_pc_valid ? start_pc : START_PC;
          end
        end
        S_READY: begin
          if (handshake && (if_warp_id == WID_W'(w))) state_d[w] = S_WAIT_ID;
        end
        S_WAIT_ID: begin
          // Slot 0 wins when both ID slots resolve the same warp
          if (id0_upd && id0_warp[w]) begin
            if (id0_exit)        state_d[w] = S_DONE;
            else if (id0_branch) state_d[w] = S_WAIT_BR;
            else begin
              state_d[w] = S_READY;
              pc_d[w]    = id0_next_pc;
            end
          end else if (id1_upd && id1_warp[w]) begin
            if (id1_exit)        state_d[w] = S_DONE;
            else if (id1_branch) state_d[w] = S_WAIT_BR;
            else begin
              state_d[w] = S_READY;
              pc_d[w]    = id1_next_pc;
            end
          end
        end
        S_WAIT_BR: begin
          if (alu_redirect && (alu_warp_id == WID_W'(w))) begin
            state_d[w] = S_READY;
            pc_d[w]    = alu_target;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: arbitration over registered state plus status flags
  always_comb begin
    if_valid   = 1'b0;
    if_warp_id = '0;
    if_pc      = '0;
    warp_busy  = '0;
    started    = '0;
    finished   = '0;
    elig       = '0;
    cand       = '0;
    for (int w = 0; w < int'(NUM_WARPS); w++) begin
      elig[w]      = (state_q[w] == S_READY) && !ib_full[w] && !simt_full[w];
      started[w]   = (state_q[w] != S_IDLE);
      finished[w]  = (state_q[w] == S_DONE);
      warp_busy[w] = started[w] && !finished[w];
    end
    // Scan lowest priority first so the last hit is the rr_ptr+1 side
    for (int i = int'(NUM_WARPS); i >= 1; i--) begin
      cand = WID_W'((int'(rr_ptr_q) + i) % int'(NUM_WARPS));
      if (elig[cand]) begin
        if_valid   = 1'b1;
        if_warp_id = cand;
        if_pc      = pc_q[cand];
      end
    end
    all_done = (|started) && (started == finished);
  end

endmodule
